// File: rtl/decode_ctrl_if.sv
// decode_ctrl_if: fetch, decoder, dispatch and trap signals of the decode stage
interface decode_ctrl_if #(parameter int PC_W = 32);
  logic            flush;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     fetch_instr;
  logic [PC_W-1:0] fetch_pc;
  logic [31:0]     dec_instr;
  logic            dec_under_shadow;
  logic            dec_legal;
  logic            dec_is_br;
  logic            dec_shadowable;
  logic            disp_valid;
  logic            disp_ready;
  logic [31:0]     disp_instr;
  logic [PC_W-1:0] disp_pc;
  logic            disp_shadowed;
  logic            disp_sfo_head;
  logic            disp_sfo_cancel;
  logic            illegal_valid;
  logic [PC_W-1:0] illegal_pc;
  modport master (
    output flush, fetch_valid, fetch_instr, fetch_pc, dec_legal, dec_is_br, dec_shadowable, disp_ready,
    input  fetch_ready, dec_instr, dec_under_shadow, disp_valid, disp_instr, disp_pc,
           disp_shadowed, disp_sfo_head, disp_sfo_cancel, illegal_valid, illegal_pc
  );
  modport slave (
    input  flush, fetch_valid, fetch_instr, fetch_pc, dec_legal, dec_is_br, dec_shadowable, disp_ready,
    output fetch_ready, dec_instr, dec_under_shadow, disp_valid, disp_instr, disp_pc,
           disp_shadowed, disp_sfo_head, disp_sfo_cancel, illegal_valid, illegal_pc
  );
endinterface

// File: rtl/decode_ctrl.sv
// decode_ctrl: decode-stage sequencer with dispatch register, illegal trap and SFO shadow FSM (enabled by DECODE_SFO_EN)
module decode_ctrl #(
  parameter int SFO_MAX_INSNS = 4,
  parameter int PC_W = 32
) (
  input logic clk,
  input logic rst_n,
  decode_ctrl_if.slave io
);
`ifdef DECODE_SFO_EN
  typedef enum logic [1:0] {RUN, SHADOW, TRAP} state_t;
`else
  typedef enum logic {RUN, TRAP} state_t;
`endif
  state_t          state_q, state_d;
  logic            disp_valid_q, disp_valid_d;
  logic [31:0]     disp_instr_q, disp_instr_d;
  logic [PC_W-1:0] disp_pc_q, disp_pc_d;
  logic            illegal_valid_q, illegal_valid_d;
  logic [PC_W-1:0] illegal_pc_q, illegal_pc_d;
  logic            accept;
  assign io.fetch_ready   = !io.flush && state_q != TRAP && (!disp_valid_q || io.disp_ready);
  assign accept           = io.fetch_valid && io.fetch_ready;
  assign io.dec_instr     = io.fetch_instr;
  assign io.disp_valid    = disp_valid_q;
  assign io.disp_instr    = disp_instr_q;
  assign io.disp_pc       = disp_pc_q;
  assign io.illegal_valid = illegal_valid_q;
  assign io.illegal_pc    = illegal_pc_q;
`ifdef DECODE_SFO_EN
  logic [3:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] exp_pc_q, exp_pc_d;
  logic            shadowed_q, shadowed_d, head_q, head_d, cancel_q, cancel_d;
  logic [12:0]     boff;
  logic            eligible, under_shadow;
  assign boff     = {io.fetch_instr[31], io.fetch_instr[7], io.fetch_instr[30:25], io.fetch_instr[11:8], 1'b0};
  assign eligible = io.dec_is_br && io.dec_legal && !boff[12] && boff[1:0] == 2'b00 &&
                    boff >= 13'd8 && boff <= 13'(4 * (SFO_MAX_INSNS + 1));
  assign under_shadow        = state_q == SHADOW && io.fetch_pc == exp_pc_q;
  assign io.dec_under_shadow = under_shadow;
  assign io.disp_shadowed    = shadowed_q;
  assign io.disp_sfo_head    = head_q;
  assign io.disp_sfo_cancel  = cancel_q;
`else
  assign io.dec_under_shadow = 1'b0;
  assign io.disp_shadowed    = 1'b0;
  assign io.disp_sfo_head    = 1'b0;
  assign io.disp_sfo_cancel  = 1'b0;
`endif
  // next state: flush beats trap capture, trap beats dispatch; shadow opens only from RUN
  always_comb begin
    state_d         = state_q;
    disp_valid_d    = disp_valid_q && !io.disp_ready;
    disp_instr_d    = disp_instr_q;
    disp_pc_d       = disp_pc_q;
    illegal_valid_d = 1'b0;
    illegal_pc_d    = illegal_pc_q;
`ifdef DECODE_SFO_EN
    cnt_d      = cnt_q;
    exp_pc_d   = exp_pc_q;
    shadowed_d = shadowed_q;
    head_d     = head_q;
    cancel_d   = cancel_q;
`endif
    if (io.flush) begin
      disp_valid_d = 1'b0;
      state_d      = RUN;
`ifdef DECODE_SFO_EN
      cnt_d = '0;
`endif
    end else if (accept && !io.dec_legal) begin
      state_d         = TRAP;
      illegal_valid_d = 1'b1;
      illegal_pc_d    = io.fetch_pc;
`ifdef DECODE_SFO_EN
      cnt_d = '0;
`endif
    end else if (accept) begin
      disp_valid_d = 1'b1;
      disp_instr_d = io.fetch_instr;
      disp_pc_d    = io.fetch_pc;
`ifdef DECODE_SFO_EN
      shadowed_d = 1'b0;
      head_d     = 1'b0;
      cancel_d   = 1'b0;
      if (state_q == SHADOW) begin
        if (under_shadow && io.dec_shadowable) begin
          shadowed_d = 1'b1;
          cnt_d      = cnt_q - 4'd1;
          exp_pc_d   = exp_pc_q + PC_W'(4);
          state_d    = cnt_q == 4'd1 ? RUN : SHADOW;
        end else begin
          cancel_d = 1'b1;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end else if (eligible) begin
        head_d   = 1'b1;
        cnt_d    = 4'(boff[6:2] - 5'd1);
        exp_pc_d = io.fetch_pc + PC_W'(4);
        state_d  = SHADOW;
      end
`endif
    end
  end
  // state and dispatch registers; async reset returns everything to idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      disp_valid_q    <= 1'b0;
      disp_instr_q    <= '0;
      disp_pc_q       <= '0;
      illegal_valid_q <= 1'b0;
      illegal_pc_q    <= '0;
`ifdef DECODE_SFO_EN
      cnt_q      <= '0;
      exp_pc_q   <= '0;
      shadowed_q <= 1'b0;
      head_q     <= 1'b0;
      cancel_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      disp_valid_q    <= disp_valid_d;
      disp_instr_q    <= disp_instr_d;
      disp_pc_q       <= disp_pc_d;
      illegal_valid_q <= illegal_valid_d;
      illegal_pc_q    <= illegal_pc_d;
`ifdef DECODE_SFO_EN
      cnt_q      <= cnt_d;
      exp_pc_q   <= exp_pc_d;
      shadowed_q <= shadowed_d;
      head_q     <= head_d;
      cancel_q   <= cancel_d;
`endif
    end
  end
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: scoreboard bench for decode_ctrl with a behavioural decode/shadow model
module tb_decode_ctrl;
  localparam int MAXI = 4;
`ifdef DECODE_SFO_EN
  localparam bit SFO_EN = 1'b1;
`else
  localparam bit SFO_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic sh;
    logic hd;
    logic cn;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [31:0] ilq[$];
  bit trapped = 1'b0;
  int shadow_left = 0;
  logic [31:0] next_pc = '0;
  logic [31:0] last_ill = '0;
  decode_ctrl_if #(.PC_W(32)) io();
  decode_ctrl #(.SFO_MAX_INSNS(MAXI), .PC_W(32)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  function automatic bit f_legal(logic [31:0] i);
    return i != 32'hFFFF_FFFF;
  endfunction
  function automatic bit f_br(logic [31:0] i);
    return i[6:0] == 7'b1100011;
  endfunction
  function automatic bit f_shd(logic [31:0] i);
    return i[6:0] == 7'b0010011 || i[6:0] == 7'b0110011;
  endfunction
  assign io.dec_legal      = f_legal(io.dec_instr);
  assign io.dec_is_br      = f_br(io.dec_instr);
  assign io.dec_shadowable = f_shd(io.dec_instr);
  function automatic logic [31:0] addi(int imm);
    logic [11:0] m;
    m = 12'(imm);
    return {m, 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction
  function automatic logic [31:0] beq(int off);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction
  localparam logic [31:0] JAL = {20'h0, 5'd1, 7'b1101111};
  function automatic int boff_of(logic [31:0] i);
    logic signed [12:0] b;
    b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    return int'(b);
  endfunction
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  function automatic void model_accept(logic [31:0] ins, logic [31:0] pc);
    exp_t e;
    int off;
    e = '{instr: ins, pc: pc, sh: 1'b0, hd: 1'b0, cn: 1'b0};
    if (!f_legal(ins)) begin
      trapped = 1'b1;
      shadow_left = 0;
      last_ill = pc;
      ilq.push_back(pc);
      return;
    end
    off = boff_of(ins);
    if (SFO_EN && shadow_left > 0) begin
      if (pc == next_pc && f_shd(ins)) begin
        e.sh = 1'b1;
        shadow_left--;
        next_pc = pc + 4;
      end else begin
        e.cn = 1'b1;
        shadow_left = 0;
      end
    end else if (SFO_EN && f_br(ins) && off >= 8 && off <= 4 * (MAXI + 1) && off % 4 == 0) begin
      e.hd = 1'b1;
      shadow_left = off / 4 - 1;
      next_pc = pc + 4;
    end
    sb.push_back(e);
  endfunction
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl, output bit acc);
    bit er;
    @(posedge clk);
    #1;
    io.fetch_valid = v;
    io.fetch_instr = ins;
    io.fetch_pc    = pc;
    io.disp_ready  = rdy;
    io.flush       = fl;
    @(negedge clk);
    #4;
    er = !fl && !trapped && (sb.size() == 0 || rdy);
    chk("fetch_ready", 32'(io.fetch_ready), 32'(er));
    chk("dec_instr", io.dec_instr, ins);
    if (v) chk("dec_under_shadow", 32'(io.dec_under_shadow), 32'(SFO_EN && shadow_left > 0 && pc == next_pc));
    acc = v && er;
    if (fl) begin
      sb.delete();
      trapped = 1'b0;
      shadow_left = 0;
    end else if (acc) model_accept(ins, pc);
  endtask
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit always_rdy);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++)
      step(1'b1, ins, pc, always_rdy || ($urandom % 10 < 7), 1'b0, acc);
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: pc %h never accepted", pc);
    end
  endtask
  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
  endtask
  // monitor: compares the dispatch register and trap pulse against the scoreboard heads
  always @(negedge clk) begin
    if (rst_n) begin
      chk("disp_valid", 32'(io.disp_valid), 32'(sb.size() != 0));
      if (io.disp_valid && sb.size() != 0) begin
        chk("disp_instr", io.disp_instr, sb[0].instr);
        chk("disp_pc", io.disp_pc, sb[0].pc);
        chk("disp_shadowed", 32'(io.disp_shadowed), 32'(sb[0].sh));
        chk("disp_sfo_head", 32'(io.disp_sfo_head), 32'(sb[0].hd));
        chk("disp_sfo_cancel", 32'(io.disp_sfo_cancel), 32'(sb[0].cn));
        if (io.disp_ready) void'(sb.pop_front());
      end
      chk("illegal_valid", 32'(io.illegal_valid), 32'(ilq.size() != 0));
      if (io.illegal_valid && ilq.size() != 0) chk("illegal_pc", io.illegal_pc, ilq.pop_front());
    end
  end
  initial begin
    bit acc, v, rd, fl;
    logic [31:0] pc, ins;
    int r;
    io.flush = 1'b0;
    io.fetch_valid = 1'b0;
    io.fetch_instr = '0;
    io.fetch_pc = '0;
    io.disp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp_valid", 32'(io.disp_valid), 32'h0);
    chk("rst_disp_pc", io.disp_pc, 32'h0);
    chk("rst_disp_instr", io.disp_instr, 32'h0);
    chk("rst_illegal_valid", 32'(io.illegal_valid), 32'h0);
    chk("rst_illegal_pc", io.illegal_pc, 32'h0);
    chk("rst_flags", {29'h0, io.disp_shadowed, io.disp_sfo_head, io.disp_sfo_cancel}, 32'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(addi(1), 32'(4 * i), 1'b1);
    idle(2);
    send(addi(2), 32'h10, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, addi(3), 32'h14, 1'b0, 1'b0, acc);
    send(addi(3), 32'h14, 1'b1);
    idle(2);
    send(beq(12), 32'h100, 1'b1);
    send(addi(4), 32'h104, 1'b1);
    send(addi(5), 32'h108, 1'b1);
    send(addi(6), 32'h10C, 1'b1);
    idle(2);
    send(beq(16), 32'h200, 1'b1);
    send(addi(7), 32'h204, 1'b1);
    send(JAL, 32'h208, 1'b1);
    send(addi(8), 32'h20C, 1'b1);
    idle(2);
    send(32'hFFFF_FFFF, 32'h300, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, addi(9), 32'h304, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, acc);
    step(1'b1, addi(9), 32'h304, 1'b1, 1'b0, acc);
    chk("illegal_pc_hold", io.illegal_pc, last_ill);
    idle(2);
    send(beq(16), 32'h400, 1'b1);
    send(addi(10), 32'h404, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    idle(1);
    send(addi(11), 32'h408, 1'b1);
    idle(2);
    send(beq(20), 32'h500, 1'b1);
    send(addi(12), 32'h504, 1'b1);
    step(1'b1, addi(13), 32'h508, 1'b0, 1'b0, acc);
    @(posedge clk);
    #3 rst_n = 1'b0;
    io.fetch_valid = 1'b0;
    #1;
    chk("arst_disp_valid", 32'(io.disp_valid), 32'h0);
    chk("arst_disp_pc", io.disp_pc, 32'h0);
    chk("arst_disp_instr", io.disp_instr, 32'h0);
    chk("arst_illegal_pc", io.illegal_pc, 32'h0);
    chk("arst_flags", {29'h0, io.disp_shadowed, io.disp_sfo_head, io.disp_sfo_cancel}, 32'h0);
    sb.delete();
    ilq.delete();
    trapped = 1'b0;
    shadow_left = 0;
    last_ill = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(addi(14), 32'h508, 1'b1);
    idle(2);
    pc = 32'h1000;
    repeat (3000) begin
      fl = trapped ? ($urandom % 3 == 0) : ($urandom % 60 == 0);
      v  = !trapped && ($urandom % 10 < 8);
      rd = $urandom % 10 < 7;
      r  = int'($urandom % 100);
      ins = r < 2 ? 32'hFFFF_FFFF : r < 25 ? beq((int'($urandom_range(0, 40)) - 8) * 2) :
            r < 33 ? JAL : addi(int'($urandom % 2048));
      step(v, ins, pc, rd, fl, acc);
      if (acc) pc = ($urandom % 12 == 0) ? ($urandom & 32'hFFFF_FFFC) : pc + 4;
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, acc);
    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
